// File: rtl/des_pkg.sv
// Shared DES tables and types for the key schedule, round datapath and S-boxes.
// Bit numbering follows the DES standard: table entry 1 is the MSB.
package des_pkg;

    typedef logic [27:0] des_half_t;
    typedef logic [47:0] des_subkey_t;

    typedef enum logic {
        ST_IDLE,
        ST_GEN
    } ks_state_t;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Entry i holds the left shift applied to produce round i+1.
    localparam logic [1:0] SHIFT [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    function automatic des_half_t rotl(input des_half_t h, input logic [1:0] n);
        return n[1] ? {h[25:0], h[27:26]} : {h[26:0], h[27]};
    endfunction

    function automatic des_half_t rotr(input des_half_t h, input logic [1:0] n);
        return n[1] ? {h[1:0], h[27:2]} : {h[0], h[27:1]};
    endfunction

endpackage

// File: rtl/des_pc2.sv
// Permuted choice 2: compresses the 56-bit {C,D} state into a 48-bit subkey.
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] cd,
    output des_subkey_t sk
);

    for (genvar i = 0; i < 48; i++) begin : g_bit
        localparam int SRC = 56 - PC2[i];
        assign sk[47-i] = cd[SRC];
    end

endmodule

// File: rtl/des_key_sched.sv
// Iterative DES subkey generator: one round key per valid/ready handshake,
// in encrypt (K1..K16) or decrypt (K16..K1) order.
module des_key_sched
    import des_pkg::*;
#(
    parameter bit DECRYPT_ONLY = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [63:0] key,
    input  logic        decrypt,
    output logic        sk_valid,
    input  logic        sk_ready,
    output logic [47:0] sk,
    output logic [3:0]  sk_round,
    output logic        sk_last,
    output logic        busy
);

    ks_state_t   state, state_nx;
    des_half_t   c_q, d_q, c_nx, d_nx, c0, d0;
    des_subkey_t sk_nx;
    logic [55:0] pc1_out;
    logic [3:0]  rnd_nx;
    logic        mode_q, mode_nx, last_nx;
    logic        dec_in, accept, step, load;

    assign dec_in    = DECRYPT_ONLY ? 1'b1 : decrypt;
    assign key_ready = (state == ST_IDLE);
    assign sk_valid  = (state == ST_GEN);
    assign busy      = sk_valid;
    assign accept    = key_valid && key_ready;
    assign step      = sk_valid && sk_ready;

    // Parity bits never appear in PC-1, so they drop out here.
    for (genvar i = 0; i < 56; i++) begin : g_pc1
        localparam int SRC = 64 - PC1[i];
        assign pc1_out[55-i] = key[SRC];
    end

    assign c0 = pc1_out[55:28];
    assign d0 = pc1_out[27:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nx = ST_GEN;
                    load     = 1'b1;
                end
            end
            ST_GEN: begin
                if (step) begin
                    if (sk_last) begin
                        state_nx = ST_IDLE;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Decrypt starts from C0/D0: 28 total shifts make it equal to C16/D16.
    always_comb begin
        c_nx    = c_q;
        d_nx    = d_q;
        rnd_nx  = sk_round;
        mode_nx = mode_q;
        if (state == ST_IDLE) begin
            mode_nx = dec_in;
            c_nx    = dec_in ? c0 : rotl(c0, 2'd1);
            d_nx    = dec_in ? d0 : rotl(d0, 2'd1);
            rnd_nx  = dec_in ? 4'd15 : 4'd0;
        end else if (mode_q) begin
            c_nx   = rotr(c_q, SHIFT[sk_round]);
            d_nx   = rotr(d_q, SHIFT[sk_round]);
            rnd_nx = sk_round - 4'd1;
        end else begin
            c_nx   = rotl(c_q, SHIFT[sk_round + 4'd1]);
            d_nx   = rotl(d_q, SHIFT[sk_round + 4'd1]);
            rnd_nx = sk_round + 4'd1;
        end
        last_nx = mode_nx ? (rnd_nx == 4'd0) : (rnd_nx == 4'd15);
    end

    des_pc2 u_pc2 (
        .cd ({c_nx, d_nx}),
        .sk (sk_nx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q      <= '0;
            d_q      <= '0;
            mode_q   <= 1'b0;
            sk       <= '0;
            sk_round <= '0;
            sk_last  <= 1'b0;
        end else if (load) begin
            c_q      <= c_nx;
            d_q      <= d_nx;
            mode_q   <= mode_nx;
            sk       <= sk_nx;
            sk_round <= rnd_nx;
            sk_last  <= last_nx;
        end
    end

endmodule

// File: tb/tb_des_key_sched.sv
// Directed bench for des_key_sched: table of key runs plus
// hand-written sequences for key_valid during GEN and mid-run reset.
module tb_des_key_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_valid;
    logic        key_ready;
    logic [63:0] key;
    logic        decrypt;
    logic        sk_valid;
    logic        sk_ready;
    logic [47:0] sk;
    logic [3:0]  sk_round;
    logic        sk_last;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] PAR = 64'h0101010101010101;

    localparam logic [47:0] KREF [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    typedef struct {
        logic [63:0] key;
        logic        dec;
        int          duty;
        int          kset;
    } vec_t;

    vec_t vecs [8];

    des_key_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key       (key),
        .decrypt   (decrypt),
        .sk_valid  (sk_valid),
        .sk_ready  (sk_ready),
        .sk        (sk),
        .sk_round  (sk_round),
        .sk_last   (sk_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] exp_sk(input int kset, input int r);
        if (kset == 1) return 48'h0;
        if (kset == 2) return 48'hFFFFFFFFFFFF;
        return KREF[r];
    endfunction

    task automatic run_seq(input vec_t v);
        int          got;
        int          budget;
        int          er;
        logic [47:0] h_sk;
        logic [3:0]  h_rnd;
        chk("idle_ready", key_ready, 1);
        key       = v.key;
        decrypt   = v.dec;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        chk("first_valid", sk_valid, 1);
        got    = 0;
        budget = 0;
        while (got < 16 && budget < 400) begin
            budget++;
            if (!sk_valid) begin
                chk("valid_early_drop", sk_valid, 1);
                break;
            end
            if (int'($urandom_range(99)) < v.duty) begin
                er = v.dec ? 15 - got : got;
                chk("sk", sk, exp_sk(v.kset, er));
                chk("sk_round", sk_round, er);
                chk("sk_last", sk_last, got == 15);
                sk_ready = 1'b1;
                @(negedge clk);
                sk_ready = 1'b0;
                got++;
            end else begin
                h_sk  = sk;
                h_rnd = sk_round;
                sk_ready = 1'b0;
                @(negedge clk);
                chk("stall_hold", {sk_valid, sk_round, sk}, {1'b1, h_rnd, h_sk});
            end
        end
        chk("handshake_count", got, 16);
        chk("ready_after", key_ready, 1);
        chk("valid_after", sk_valid, 0);
    endtask

    initial begin
        int budget;
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key       = '0;
        decrypt   = 1'b0;
        sk_ready  = 1'b0;

        vecs[0] = '{KEY,       1'b0, 100, 0};
        vecs[1] = '{KEY,       1'b1, 100, 0};
        vecs[2] = '{KEY,       1'b0,  40, 0};
        vecs[3] = '{KEY,       1'b1,  40, 0};
        vecs[4] = '{KEY ^ PAR, 1'b0, 100, 0};
        vecs[5] = '{KEY ^ PAR, 1'b1,  40, 0};
        vecs[6] = '{64'h0,     1'b0, 100, 1};
        vecs[7] = '{~64'h0,    1'b1,  60, 2};

        @(negedge clk);
        @(negedge clk);
        chk("rst_key_ready", key_ready, 1);
        chk("rst_outputs", {sk_valid, busy, sk_last, sk_round, sk}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_seq(vecs[i]);
        end

        // key_valid held with another key and mode through a whole run
        key       = KEY;
        decrypt   = 1'b0;
        key_valid = 1'b1;
        @(negedge clk);
        key       = 64'h0;
        decrypt   = 1'b1;
        sk_ready  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("gen_busy", busy, 1);
            chk("gen_sk", sk, KREF[i]);
            chk("gen_round", sk_round, i);
            @(negedge clk);
        end
        chk("gen_end_ready", key_ready, 1);
        chk("gen_end_valid", sk_valid, 0);
        @(negedge clk);
        key_valid = 1'b0;
        chk("next_accept", {sk_valid, sk_round, sk}, {1'b1, 4'd15, 48'h0});
        budget = 0;
        while (!key_ready && budget < 40) begin
            budget++;
            @(negedge clk);
        end
        sk_ready = 1'b0;
        chk("drain_done", key_ready, 1);

        // reset while the 7th subkey is presented
        key       = KEY;
        decrypt   = 1'b0;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        sk_ready  = 1'b1;
        for (int i = 0; i < 6; i++) @(negedge clk);
        sk_ready = 1'b0;
        chk("k7_before_rst", sk, KREF[6]);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_valid", sk_valid, 0);
        chk("rst_async_ready", key_ready, 1);
        chk("rst_async_out", {busy, sk_last, sk_round, sk}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_seq(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
